issue_scheduler: RTL and testbench
==================================

Name: issue_scheduler

Overview:
Dual-issue dispatch controller between the instruction queue and the reservation stations (RS) of the Tomasulo core.
- Tracks occupancy of the ADD-unit and MUL-unit RS entries.
- Decides each cycle whether 0, 1 or 2 queued instructions issue in order, and assigns each issued instruction an RS tag.
- Frees entries when their tag is broadcast on the common data bus (CDB).
- Drives select_instruction back to the instruction queue.

Parameters:
ADD_RS, 3, number of ADD/SUB reservation-station entries
MUL_RS, 2, number of MUL/DIV reservation-station entries
TAG_W, 3, tag width; ADD_RS+MUL_RS must not exceed 2**TAG_W

Ports:
clk  in  1  single clock, rising edge
reset  in  1  synchronous, active-high reset
inst1_valid  in  1  queue slot 1 holds an instruction
inst1_type  in  8  opcode of slot 1 (oldest)
inst2_valid  in  1  queue slot 2 holds an instruction
inst2_type  in  8  opcode of slot 2
cdb_valid  in  1  CDB broadcast this cycle
cdb_tag  in  TAG_W  tag completing on CDB
drain_req  in  1  stop issuing and wait for all RS empty
select_instruction  out  2  00 none, 01 one issued, 10 two issued
issue1_valid  out  1  slot 1 issues this cycle
issue1_tag  out  TAG_W  RS tag for slot 1
issue2_valid  out  1  slot 2 issues this cycle
issue2_tag  out  TAG_W  RS tag for slot 2
add_free  out  2  free ADD entries (registered)
mul_free  out  2  free MUL entries (registered)
drain_done  out  1  one-cycle pulse when DRAIN completes
stall_cycles  out  16  cycles with inst1_valid=1 in RUN but no issue
protocol_err  out  1  sticky: CDB released a tag that was already free

Behaviour:
- Interface is decided: one clock, clk; reset is synchronous and active-high, named reset.
- Reset values:
  - All RS entries are free; state is IDLE.
  - select_instruction=00 and all issue*_valid=0.
  - add_free=ADD_RS and mul_free=MUL_RS.
  - stall_cycles=0, protocol_err=0, drain_done=0.
- Unit mapping:
  - OP_ADD and OP_SUB go to the ADD RS; OP_MUL and OP_DIV go to the MUL RS.
  - ADD tags are 0..ADD_RS-1; MUL tags are ADD_RS..ADD_RS+MUL_RS-1.
  - Any other opcode is a NOP: it issues with no allocation, and its tag output is 0.
- Issue decision:
  - Combinational from the registered occupancy and the current inputs; the occupancy update happens at the next rising edge (zero-cycle decision, one-cycle effect).
  - Issue is strictly in order. Slot 1 issues if it is valid and its unit has at least one free entry.
  - Slot 2 issues only if slot 1 issues, slot 2 is valid, and its unit still has a free entry after slot 1's allocation. Same unit needs 2 free entries.
- Tag selection: slot 1 gets the lowest-index free entry of its unit. If both slots use the same unit, slot 2 gets the next-lowest free entry.
- select_instruction: 10 if both slots issue, 01 if only slot 1, else 00. It is never 10 with issue1_valid=0.
- CDB release:
  - At the edge, the entry matching cdb_tag is freed.
  - There is no same-cycle bypass: a freed entry becomes allocatable the next cycle.
  - A release of a free entry, or of a tag >= ADD_RS+MUL_RS, sets protocol_err and does not alter occupancy.
  - Allocation and release in the same cycle are both applied; they can never target the same entry.
- FSM:
  - IDLE: no issue. Go to RUN when inst1_valid=1 and drain_req=0.
  - RUN: issue per the rules above. Go to DRAIN when drain_req=1; drain_req blocks issue in that same cycle.
  - DRAIN: no issue; releases continue. Go to IDLE, pulsing drain_done for one cycle, once all entries are free. If already empty on entry, this happens in the next cycle.
- stall_cycles: increments in RUN when inst1_valid=1 and slot 1 does not issue. It saturates at 0xFFFF.
- reset mid-operation: all allocations are discarded and the block returns to reset values at that edge; CDB input is ignored on the reset cycle.

Decomposition:
- Shared package (extend the existing definitions file) holds:
  - opcode constants OP_ADD, OP_SUB, OP_MUL, OP_DIV;
  - the FSM state encoding ST_IDLE, ST_RUN, ST_DRAIN;
  - default RS sizes.
- One sub-module, rs_alloc, is natural. It is parameterised by entry count and tag base, and instantiated twice (ADD, MUL).
  - Occupancy bit vector plus first and second free-index finders.
  - Free count, release port and error flag.

Test Plan:
- Reset, then MUL,ADD valid (both units empty) -> select=10, tag1=3, tag2=0; next cycle add_free=2, mul_free=1.
- Three MULs fed back to back with no CDB -> cycle 1 select=01 (tag 3); cycle 2: slot 1 issues tag 4, slot 2 blocked so select=01; cycle 3 select=00 and stall_cycles increments. Then cdb tag 3 -> the following cycle issues tag 3.
- ADD,ADD with add_free=1 -> select=01, issue2_valid=0. With add_free=0 in RUN -> select=00 even if slot 2 is a MUL with room (in-order rule).
- Release of already-free tag 1 -> protocol_err=1 sticky, free counts unchanged; also test cdb_tag=6.
- Fill 2 ADD + 1 MUL, assert drain_req -> no issue while draining; CDB tags 0,1,3 -> drain_done pulses the cycle after the last release; state IDLE.
- Assert reset with 4 entries busy -> next cycle add_free=3, mul_free=2, stall_cycles=0, select=00.

Source files
------------

// File: rtl/issue_scheduler_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : issue_scheduler_pkg
//  Description : Shared definitions for the dual-issue scheduler: opcode
//                constants, FSM state encoding, default reservation-station
//                sizes and opcode-to-unit classification helpers.
//  Revision    : 1.0  initial release
// ============================================================================
package issue_scheduler_pkg;

   // Default reservation-station geometry
   localparam int DEF_ADD_RS = 3;
   localparam int DEF_MUL_RS = 2;
   localparam int DEF_TAG_W  = 3;

   // Opcodes routed to a reservation station; anything else is a NOP
   localparam logic [7:0] OP_ADD = 8'h01;
   localparam logic [7:0] OP_SUB = 8'h02;
   localparam logic [7:0] OP_MUL = 8'h03;
   localparam logic [7:0] OP_DIV = 8'h04;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;

   function automatic logic is_add_op(input logic [7:0] op);
      return (op == OP_ADD) || (op == OP_SUB);
   endfunction

   function automatic logic is_mul_op(input logic [7:0] op);
      return (op == OP_MUL) || (op == OP_DIV);
   endfunction

endpackage
`default_nettype wire

// File: rtl/issue_scheduler_rs_alloc.sv
`default_nettype none
// ============================================================================
//  Module      : rs_alloc
//  Description : Occupancy tracker for one group of reservation-station
//                entries. Finds the lowest and second-lowest free entries,
//                applies up to two allocations plus one CDB release per cycle
//                and keeps a registered free count.
//  Ports       : clk/reset        - clock, synchronous active-high reset
//                alloc_first      - claim the lowest free entry this cycle
//                alloc_second     - claim the second-lowest free entry
//                rel_valid/rel_tag- CDB release (global tag space)
//                first_ok/_tag    - lowest free entry exists / its tag
//                second_ok/_tag   - second free entry exists / its tag
//                free_cnt         - registered number of free entries
//                empty            - no entry is busy
//                rel_err          - release targets an entry of this group
//                                   that is already free
//  Revision    : 1.0  initial release
// ============================================================================
module rs_alloc #(
   parameter int N     = 3,
   parameter int BASE  = 0,
   parameter int TAG_W = 3,
   parameter int CNT_W = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             alloc_first,
   input  logic             alloc_second,
   input  logic             rel_valid,
   input  logic [TAG_W-1:0] rel_tag,
   output logic             first_ok,
   output logic [TAG_W-1:0] first_tag,
   output logic             second_ok,
   output logic [TAG_W-1:0] second_tag,
   output logic [CNT_W-1:0] free_cnt,
   output logic             empty,
   output logic             rel_err
);

   logic [N-1:0]     busy;
   logic [N-1:0]     first_mask;
   logic [N-1:0]     second_mask;
   logic [N-1:0]     clr_mask;
   logic [N-1:0]     busy_next;
   logic [CNT_W-1:0] free_next;

   // Free-entry search, release decode and next-occupancy computation.
   always_comb begin
      first_ok    = 1'b0;
      first_tag   = '0;
      first_mask  = '0;
      second_ok   = 1'b0;
      second_tag  = '0;
      second_mask = '0;
      clr_mask    = '0;
      rel_err     = 1'b0;
      for (int i = 0; i < N; i++) begin
         if (!busy[i]) begin
            if (!first_ok) begin
               first_ok      = 1'b1;
               first_tag     = TAG_W'(BASE + i);
               first_mask[i] = 1'b1;
            end else if (!second_ok) begin
               second_ok      = 1'b1;
               second_tag     = TAG_W'(BASE + i);
               second_mask[i] = 1'b1;
            end
         end
         if (rel_valid && (rel_tag == TAG_W'(BASE + i))) begin
            if (busy[i]) clr_mask[i] = 1'b1;
            else         rel_err     = 1'b1;
         end
      end
      // Allocations only ever hit free entries and releases only busy ones,
      // so set and clear masks are disjoint.
      busy_next = (busy | (alloc_first  ? first_mask  : '0)
                        | (alloc_second ? second_mask : '0)) & ~clr_mask;
      free_next = '0;
      for (int i = 0; i < N; i++) begin
         if (!busy_next[i]) free_next = free_next + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         busy     <= '0;
         free_cnt <= CNT_W'(N);
      end else begin
         busy     <= busy_next;
         free_cnt <= free_next;
      end
   end

   assign empty = (busy == '0);

endmodule
`default_nettype wire

// File: rtl/issue_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : issue_scheduler
//  Description : Dual-issue in-order dispatch controller between the
//                instruction queue and the ADD/MUL reservation stations.
//  Ports       : inst1_*/inst2_*      - oldest two queue slots
//                cdb_valid/cdb_tag    - completion broadcast, frees an entry
//                drain_req            - stop issuing, wait for RS empty
//                select_instruction   - 00 none, 01 one, 10 two issued
//                issue1_*/issue2_*    - per-slot issue strobe and RS tag
//                add_free/mul_free    - registered free-entry counts
//                drain_done           - pulse when drain completes
//                stall_cycles         - saturating RUN stall counter
//                protocol_err         - sticky bad-release flag
//  Revision    : 1.0  initial release
// ============================================================================
module issue_scheduler
   import issue_scheduler_pkg::*;
#(
   parameter int ADD_RS = DEF_ADD_RS,
   parameter int MUL_RS = DEF_MUL_RS,
   parameter int TAG_W  = DEF_TAG_W
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             inst1_valid,
   input  logic [7:0]       inst1_type,
   input  logic             inst2_valid,
   input  logic [7:0]       inst2_type,
   input  logic             cdb_valid,
   input  logic [TAG_W-1:0] cdb_tag,
   input  logic             drain_req,
   output logic [1:0]       select_instruction,
   output logic             issue1_valid,
   output logic [TAG_W-1:0] issue1_tag,
   output logic             issue2_valid,
   output logic [TAG_W-1:0] issue2_tag,
   output logic [1:0]       add_free,
   output logic [1:0]       mul_free,
   output logic             drain_done,
   output logic [15:0]      stall_cycles,
   output logic             protocol_err
);

   state_t state, state_next;

   logic             issue_en;
   logic             u1_add, u1_mul, u2_add, u2_mul;
   logic             can1, room2;
   logic             add_a1, add_a2, mul_a1, mul_a2;
   logic             add_f_ok, add_s_ok, mul_f_ok, mul_s_ok;
   logic [TAG_W-1:0] add_f_tag, add_s_tag, mul_f_tag, mul_s_tag;
   logic             add_empty, mul_empty, add_err, mul_err, tag_oor;

   assign u1_add = is_add_op(inst1_type);
   assign u1_mul = is_mul_op(inst1_type);
   assign u2_add = is_add_op(inst2_type);
   assign u2_mul = is_mul_op(inst2_type);

   // Slot 1 needs one free entry in its unit; NOPs always have room.
   assign can1 = inst1_valid && (u1_add ? add_f_ok : (u1_mul ? mul_f_ok : 1'b1));
   // Slot 2 sees its unit after slot 1's claim: second free entry if shared.
   assign room2 = u2_add ? (u1_add ? add_s_ok : add_f_ok) :
                  u2_mul ? (u1_mul ? mul_s_ok : mul_f_ok) : 1'b1;

   assign issue1_valid = issue_en && can1;
   assign issue2_valid = issue1_valid && inst2_valid && room2;
   assign select_instruction = issue2_valid ? 2'b10 : (issue1_valid ? 2'b01 : 2'b00);

   assign issue1_tag = u1_add ? add_f_tag : (u1_mul ? mul_f_tag : '0);
   assign issue2_tag = u2_add ? (u1_add ? add_s_tag : add_f_tag) :
                       u2_mul ? (u1_mul ? mul_s_tag : mul_f_tag) : '0;

   // Slot 2 takes the lowest free entry unless slot 1 already claimed it.
   assign add_a1 = (issue1_valid && u1_add) || (issue2_valid && u2_add && !u1_add);
   assign add_a2 = issue1_valid && u1_add && issue2_valid && u2_add;
   assign mul_a1 = (issue1_valid && u1_mul) || (issue2_valid && u2_mul && !u1_mul);
   assign mul_a2 = issue1_valid && u1_mul && issue2_valid && u2_mul;

   assign tag_oor = cdb_valid && (32'(cdb_tag) >= 32'(ADD_RS + MUL_RS));

   rs_alloc #(.N(ADD_RS), .BASE(0), .TAG_W(TAG_W), .CNT_W(2)) u_add_rs (
      .clk(clk), .reset(reset),
      .alloc_first(add_a1), .alloc_second(add_a2),
      .rel_valid(cdb_valid), .rel_tag(cdb_tag),
      .first_ok(add_f_ok), .first_tag(add_f_tag),
      .second_ok(add_s_ok), .second_tag(add_s_tag),
      .free_cnt(add_free), .empty(add_empty), .rel_err(add_err)
   );

   rs_alloc #(.N(MUL_RS), .BASE(ADD_RS), .TAG_W(TAG_W), .CNT_W(2)) u_mul_rs (
      .clk(clk), .reset(reset),
      .alloc_first(mul_a1), .alloc_second(mul_a2),
      .rel_valid(cdb_valid), .rel_tag(cdb_tag),
      .first_ok(mul_f_ok), .first_tag(mul_f_tag),
      .second_ok(mul_s_ok), .second_tag(mul_s_tag),
      .free_cnt(mul_free), .empty(mul_empty), .rel_err(mul_err)
   );

   always_ff @(posedge clk) begin
      if (reset) state <= ST_IDLE;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      issue_en   = 1'b0;
      drain_done = 1'b0;
      case (state)
         ST_IDLE: begin
            if (inst1_valid && !drain_req) state_next = ST_RUN;
         end
         ST_RUN: begin
            if (drain_req) state_next = ST_DRAIN;
            else           issue_en   = 1'b1;
         end
         ST_DRAIN: begin
            if (add_empty && mul_empty) begin
               drain_done = 1'b1;
               state_next = ST_IDLE;
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         stall_cycles <= 16'd0;
         protocol_err <= 1'b0;
      end else begin
         if ((state == ST_RUN) && inst1_valid && !issue1_valid && (stall_cycles != 16'hFFFF))
            stall_cycles <= stall_cycles + 16'd1;
         if (add_err || mul_err || tag_oor)
            protocol_err <= 1'b1;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_issue_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_issue_scheduler
//  Description : Directed self-checking bench for issue_scheduler.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_issue_scheduler;
   import issue_scheduler_pkg::*;

   logic       clk = 1'b0;
   logic       reset;
   logic       inst1_valid, inst2_valid;
   logic [7:0] inst1_type, inst2_type;
   logic       cdb_valid;
   logic [2:0] cdb_tag;
   logic       drain_req;
   logic [1:0] select_instruction;
   logic       issue1_valid, issue2_valid;
   logic [2:0] issue1_tag, issue2_tag;
   logic [1:0] add_free, mul_free;
   logic       drain_done;
   logic [15:0] stall_cycles;
   logic       protocol_err;

   int checks = 0;
   int errors = 0;

   localparam logic [7:0] OP_NOP = 8'hFF;

   issue_scheduler dut (
      .clk(clk), .reset(reset),
      .inst1_valid(inst1_valid), .inst1_type(inst1_type),
      .inst2_valid(inst2_valid), .inst2_type(inst2_type),
      .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .drain_req(drain_req),
      .select_instruction(select_instruction),
      .issue1_valid(issue1_valid), .issue1_tag(issue1_tag),
      .issue2_valid(issue2_valid), .issue2_tag(issue2_tag),
      .add_free(add_free), .mul_free(mul_free), .drain_done(drain_done),
      .stall_cycles(stall_cycles), .protocol_err(protocol_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Advance past the next rising edge, then settle to mid-cycle for checks.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #4;
   endtask

   task automatic insts(input logic v1, input logic [7:0] t1, input logic v2, input logic [7:0] t2);
      inst1_valid = v1; inst1_type = t1;
      inst2_valid = v2; inst2_type = t2;
   endtask

   task automatic cdb(input logic v, input logic [2:0] t);
      cdb_valid = v; cdb_tag = t;
   endtask

   initial begin
      reset = 1'b1; drain_req = 1'b0;
      insts(1'b0, OP_NOP, 1'b0, OP_NOP);
      cdb(1'b0, 3'd0);
      tick(); tick();
      reset = 1'b0;
      settle();
      check("rst_select", 32'(select_instruction), 32'd0);
      check("rst_issue", 32'({issue1_valid, issue2_valid}), 32'd0);
      check("rst_add_free", 32'(add_free), 32'd3);
      check("rst_mul_free", 32'(mul_free), 32'd2);
      check("rst_stall", 32'(stall_cycles), 32'd0);
      check("rst_perr", 32'(protocol_err), 32'd0);
      check("rst_drain_done", 32'(drain_done), 32'd0);

      // MUL,ADD: IDLE cycle first, then dual issue on empty units
      tick();
      insts(1'b1, OP_MUL, 1'b1, OP_ADD);
      settle();
      check("idle_no_issue", 32'(select_instruction), 32'd0);
      tick(); settle();
      check("dual_select", 32'(select_instruction), 32'd2);
      check("dual_tag1", 32'(issue1_tag), 32'd3);
      check("dual_tag2", 32'(issue2_tag), 32'd0);
      tick();
      insts(1'b0, OP_NOP, 1'b0, OP_NOP);
      settle();
      check("dual_add_free", 32'(add_free), 32'd2);
      check("dual_mul_free", 32'(mul_free), 32'd1);
      check("quiet_select", 32'(select_instruction), 32'd0);

      // Return both entries
      tick(); cdb(1'b1, 3'd0);
      tick(); cdb(1'b1, 3'd3);
      tick(); cdb(1'b0, 3'd0);
      settle();
      check("rel_add_free", 32'(add_free), 32'd3);
      check("rel_mul_free", 32'(mul_free), 32'd2);

      // Three MULs back to back
      tick(); insts(1'b1, OP_MUL, 1'b0, OP_NOP); settle();
      check("mul1_select", 32'(select_instruction), 32'd1);
      check("mul1_tag", 32'(issue1_tag), 32'd3);
      tick(); insts(1'b1, OP_MUL, 1'b1, OP_MUL); settle();
      check("mul2_select", 32'(select_instruction), 32'd1);
      check("mul2_tag", 32'(issue1_tag), 32'd4);
      check("mul2_slot2", 32'(issue2_valid), 32'd0);
      tick(); insts(1'b1, OP_MUL, 1'b0, OP_NOP); cdb(1'b1, 3'd3); settle();
      check("mul3_stall_select", 32'(select_instruction), 32'd0);
      check("mul3_stall_cnt0", 32'(stall_cycles), 32'd0);
      tick(); cdb(1'b0, 3'd0); settle();
      check("mul3_stall_cnt1", 32'(stall_cycles), 32'd1);
      check("mul3_reissue_sel", 32'(select_instruction), 32'd1);
      check("mul3_reissue_tag", 32'(issue1_tag), 32'd3);
      tick(); insts(1'b0, OP_NOP, 1'b0, OP_NOP); settle();
      check("mul_full", 32'(mul_free), 32'd0);

      // ADD,ADD with room for two, then with one, then in-order block
      tick(); insts(1'b1, OP_ADD, 1'b1, OP_ADD); settle();
      check("aa_sel", 32'(select_instruction), 32'd2);
      check("aa_tags", 32'({issue1_tag, issue2_tag}), 32'({3'd0, 3'd1}));
      tick(); cdb(1'b1, 3'd4); settle();
      check("aa1_add_free", 32'(add_free), 32'd1);
      check("aa1_sel", 32'(select_instruction), 32'd1);
      check("aa1_tag", 32'(issue1_tag), 32'd2);
      check("aa1_slot2", 32'(issue2_valid), 32'd0);
      tick(); cdb(1'b0, 3'd0); insts(1'b1, OP_ADD, 1'b1, OP_MUL); settle();
      check("inorder_mul_room", 32'(mul_free), 32'd1);
      check("inorder_sel", 32'(select_instruction), 32'd0);
      check("inorder_slot2", 32'(issue2_valid), 32'd0);
      tick(); insts(1'b0, OP_NOP, 1'b0, OP_NOP); settle();
      check("inorder_stall", 32'(stall_cycles), 32'd2);

      // Free everything, then release an already-free tag
      cdb(1'b1, 3'd0); tick();
      cdb(1'b1, 3'd1); tick();
      cdb(1'b1, 3'd2); tick();
      cdb(1'b1, 3'd3); tick();
      cdb(1'b0, 3'd0); settle();
      check("empty_add", 32'(add_free), 32'd3);
      check("empty_mul", 32'(mul_free), 32'd2);
      check("perr_clear", 32'(protocol_err), 32'd0);
      tick(); cdb(1'b1, 3'd1);
      tick(); cdb(1'b0, 3'd0); settle();
      check("perr_double_rel", 32'(protocol_err), 32'd1);
      check("perr_add_free", 32'(add_free), 32'd3);
      check("perr_mul_free", 32'(mul_free), 32'd2);
      tick(); settle();
      check("perr_sticky", 32'(protocol_err), 32'd1);

      // Drain: fill 2 ADD + 1 MUL, then drain
      tick(); insts(1'b1, OP_ADD, 1'b1, OP_MUL); settle();
      check("dr_fill_sel", 32'(select_instruction), 32'd2);
      tick(); insts(1'b1, OP_ADD, 1'b0, OP_NOP); settle();
      check("dr_fill2_tag", 32'(issue1_tag), 32'd1);
      tick(); drain_req = 1'b1; settle();
      check("dr_req_blocks", 32'(select_instruction), 32'd0);
      tick(); drain_req = 1'b0; cdb(1'b1, 3'd0); settle();
      check("dr_no_issue", 32'(issue1_valid), 32'd0);
      check("dr_busy0", 32'(drain_done), 32'd0);
      tick(); cdb(1'b1, 3'd1); settle();
      check("dr_busy1", 32'(drain_done), 32'd0);
      tick(); cdb(1'b1, 3'd3); settle();
      check("dr_busy2", 32'(drain_done), 32'd0);
      tick(); cdb(1'b0, 3'd0); settle();
      check("dr_done", 32'(drain_done), 32'd1);
      check("dr_done_sel", 32'(select_instruction), 32'd0);
      tick(); settle();
      check("dr_idle_pulse_end", 32'(drain_done), 32'd0);
      check("dr_idle_no_issue", 32'(select_instruction), 32'd0);

      // Reset with four entries busy (IDLE->RUN this cycle)
      tick(); insts(1'b1, OP_ADD, 1'b1, OP_ADD); settle();
      check("fill_aa", 32'({issue1_tag, issue2_tag}), 32'({3'd0, 3'd1}));
      tick(); insts(1'b1, OP_ADD, 1'b1, OP_MUL); settle();
      check("fill_am", 32'({issue1_tag, issue2_tag}), 32'({3'd2, 3'd3}));
      tick(); insts(1'b0, OP_NOP, 1'b0, OP_NOP); settle();
      check("fill_add_free", 32'(add_free), 32'd0);
      check("fill_mul_free", 32'(mul_free), 32'd1);
      reset = 1'b1; cdb(1'b1, 3'd0); insts(1'b1, OP_ADD, 1'b0, OP_NOP);
      tick();
      reset = 1'b0; cdb(1'b0, 3'd0); insts(1'b0, OP_NOP, 1'b0, OP_NOP); settle();
      check("mrst_add_free", 32'(add_free), 32'd3);
      check("mrst_mul_free", 32'(mul_free), 32'd2);
      check("mrst_stall", 32'(stall_cycles), 32'd0);
      check("mrst_select", 32'(select_instruction), 32'd0);
      check("mrst_perr", 32'(protocol_err), 32'd0);

      // Out-of-range tag
      tick(); cdb(1'b1, 3'd6);
      tick(); cdb(1'b0, 3'd0); settle();
      check("oor_perr", 32'(protocol_err), 32'd1);
      check("oor_counts", 32'({add_free, mul_free}), 32'({2'd3, 2'd2}));

      // NOP in slot 1 issues without allocating
      tick(); insts(1'b1, OP_NOP, 1'b0, OP_NOP);
      tick(); insts(1'b1, OP_NOP, 1'b1, OP_ADD); settle();
      check("nop_sel", 32'(select_instruction), 32'd2);
      check("nop_tags", 32'({issue1_tag, issue2_tag}), 32'({3'd0, 3'd0}));
      tick(); insts(1'b0, OP_NOP, 1'b0, OP_NOP); settle();
      check("nop_alloc", 32'({add_free, mul_free}), 32'({2'd2, 2'd2}));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
